// File: rtl/bram_dp.sv
// True dual-port, byte-enabled block RAM with selectable read latency and write mode.
// Define BRAM_DP_CLEAR_EN to build the post-reset memory-clear engine that drives busy.
module bram_dp #(
    parameter int BYTES       = 4,
    parameter int ADDR_W      = 15,
    parameter int DEPTH       = 24576,
    parameter int LATENCY     = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                 clka,
    input  logic                 rstn,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [BYTES-1:0]     bea,
    input  logic [ADDR_W-1:0]    adra,
    input  logic [8*BYTES-1:0]   wda,
    output logic [8*BYTES-1:0]   rda,
    output logic                 rvalida,
    input  logic                 enb,
    input  logic                 web,
    input  logic [BYTES-1:0]     beb,
    input  logic [ADDR_W-1:0]    adrb,
    input  logic [8*BYTES-1:0]   wdb,
    output logic [8*BYTES-1:0]   rdb,
    output logic                 rvalidb,
    output logic                 busy
);
    localparam int W     = 8 * BYTES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = AW1'(DEPTH);

    logic [W-1:0] mem [DEPTH];

`ifdef BRAM_DP_CLEAR_EN
    logic             busy_q;
    logic [IDX_W-1:0] clr_cnt;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            busy_q  <= 1'b1;
            clr_cnt <= '0;
        end else if (busy_q) begin
            if (clr_cnt == IDX_W'(DEPTH - 1)) busy_q <= 1'b0;
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    logic             acc_a, acc_b, in_a, in_b, same;
    logic [IDX_W-1:0] idx_a, idx_b, widx_a;
    logic [W-1:0]     old_a, old_b, new_a, new_b, rdat_a, rdat_b, wdat_a;
    logic [BYTES-1:0] lane_a, lane_b;
    logic             we_a, we_b;

    // Port A wins per lane on a same-address double write, so it stores the merged
    // word for both ports and port B's write is suppressed.
    always_comb begin
        acc_a  = ena & ~busy;
        acc_b  = enb & ~busy;
        in_a   = {1'b0, adra} < DEPTH_C;
        in_b   = {1'b0, adrb} < DEPTH_C;
        idx_a  = adra[IDX_W-1:0];
        idx_b  = adrb[IDX_W-1:0];
        same   = in_a & in_b & (adra == adrb);
        old_a  = '0;
        old_b  = '0;
        if (in_a) old_a = mem[idx_a];
        if (in_b) old_b = mem[idx_b];
        lane_a = (acc_a & wea & in_a) ? bea : '0;
        lane_b = (acc_b & web & in_b) ? beb : '0;
        new_a  = old_a;
        new_b  = old_b;
        for (int i = 0; i < BYTES; i++) begin
            if (lane_a[i])              new_a[8*i +: 8] = wda[8*i +: 8];
            else if (same && lane_b[i]) new_a[8*i +: 8] = wdb[8*i +: 8];
            if (same && lane_a[i])      new_b[8*i +: 8] = wda[8*i +: 8];
            else if (lane_b[i])         new_b[8*i +: 8] = wdb[8*i +: 8];
        end
        we_a   = |lane_a;
        we_b   = (|lane_b) & ~(same & (|lane_a));
        widx_a = idx_a;
        wdat_a = new_a;
`ifdef BRAM_DP_CLEAR_EN
        if (busy_q) begin
            we_a   = 1'b1;
            widx_a = clr_cnt;
            wdat_a = '0;
        end
`endif
        rdat_a = '0;
        rdat_b = '0;
        if (in_a) rdat_a = (WRITE_FIRST != 0) ? new_a : old_a;
        if (in_b) rdat_b = (WRITE_FIRST != 0) ? new_b : old_b;
    end

    // NOTE: the storage array has no reset branch; resetting it would prevent block-RAM inference.
    always_ff @(posedge clka) begin
        if (we_a) mem[widx_a] <= wdat_a;
        if (we_b) mem[idx_b]  <= new_b;
    end

    logic         v1a, v1b;
    logic [W-1:0] d1a, d1b;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            v1a <= 1'b0;
            v1b <= 1'b0;
            d1a <= '0;
            d1b <= '0;
        end else begin
            v1a <= acc_a;
            v1b <= acc_b;
            if (acc_a) d1a <= rdat_a;
            if (acc_b) d1b <= rdat_b;
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic         v2a, v2b;
            logic [W-1:0] d2a, d2b;

            always_ff @(posedge clka or negedge rstn) begin
                if (!rstn) begin
                    v2a <= 1'b0;
                    v2b <= 1'b0;
                    d2a <= '0;
                    d2b <= '0;
                end else begin
                    v2a <= v1a;
                    v2b <= v1b;
                    if (v1a) d2a <= d1a;
                    if (v1b) d2b <= d1b;
                end
            end

            assign rda     = d2a;
            assign rdb     = d2b;
            assign rvalida = v2a;
            assign rvalidb = v2b;
        end else begin : g_lat1
            assign rda     = d1a;
            assign rdb     = d1b;
            assign rvalida = v1a;
            assign rvalidb = v1b;
        end
    endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// Randomized bench for bram_dp: one write-first/latency-1 instance and one read-first/latency-2
// instance share stimulus and are checked against a word-level memory model.
module tb_bram_dp;
    localparam int BYTES  = 4;
    localparam int W      = 8 * BYTES;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 48;
`ifdef BRAM_DP_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              ena, wea, enb, web;
    logic [BYTES-1:0]  bea, beb;
    logic [ADDR_W-1:0] adra, adrb;
    logic [W-1:0]      wda, wdb;
    logic [W-1:0]      rda0, rdb0, rda1, rdb1;
    logic              rvalida0, rvalidb0, rvalida1, rvalidb1, busy0, busy1;

    always #5 clk = ~clk;

    bram_dp #(.BYTES(BYTES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(1), .WRITE_FIRST(1)) u_wf1 (
        .clka(clk), .rstn(rstn),
        .ena(ena), .wea(wea), .bea(bea), .adra(adra), .wda(wda), .rda(rda0), .rvalida(rvalida0),
        .enb(enb), .web(web), .beb(beb), .adrb(adrb), .wdb(wdb), .rdb(rdb0), .rvalidb(rvalidb0),
        .busy(busy0)
    );

    bram_dp #(.BYTES(BYTES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(2), .WRITE_FIRST(0)) u_rf2 (
        .clka(clk), .rstn(rstn),
        .ena(ena), .wea(wea), .bea(bea), .adra(adra), .wda(wda), .rda(rda1), .rvalida(rvalida1),
        .enb(enb), .web(web), .beb(beb), .adrb(adrb), .wdb(wdb), .rdb(rdb1), .rvalidb(rvalidb1),
        .busy(busy1)
    );

    // Model: word array with per-lane "known" flags, plus a 4-slot calendar of expected
    // read results per channel (0/1 = write-first A/B, 2/3 = read-first A/B).
    logic [W-1:0]     mm [DEPTH];
    logic [BYTES-1:0] mk [DEPTH];
    logic             pv  [4][4];
    logic             pk  [4][4];
    logic [W-1:0]     pd  [4][4];
    logic [W-1:0]     last_d [4];
    logic             last_k [4];
    int               cyc, clr_left;
    int               tests, fails;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] got_d(input int c);
        case (c)
            0:       return rda0;
            1:       return rdb0;
            2:       return rda1;
            default: return rdb1;
        endcase
    endfunction

    function automatic logic got_v(input int c);
        case (c)
            0:       return rvalida0;
            1:       return rvalidb0;
            2:       return rvalida1;
            default: return rvalidb1;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 4; s++) pv[c][s] = 1'b0;
            last_d[c] = '0;
            last_k[c] = 1'b1;
        end
        clr_left = CLEAR ? DEPTH : 0;
        if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mm[i] = '0;
                mk[i] = '1;
            end
        end
    endtask

    task automatic push(input int c, input int lat, input logic [W-1:0] d, input logic k);
        int s;
        s = (cyc + lat) % 4;
        pv[c][s] = 1'b1;
        pd[c][s] = d;
        pk[c][s] = k;
    endtask

    // Apply the current inputs to the model, advance one clock, compare all outputs.
    task automatic step();
        logic         ga, gb, ia, ib, ka, kb, kfa, kfb, r;
        logic [W-1:0] oa, ob, fa, fb;
        int           s;
        r  = rstn;
        ga = r && ena && (clr_left == 0);
        gb = r && enb && (clr_left == 0);
        ia = int'(adra) < DEPTH;
        ib = int'(adrb) < DEPTH;
        oa = '0; ob = '0; ka = 1'b1; kb = 1'b1;
        if (ia) begin oa = mm[adra]; ka = &mk[adra]; end
        if (ib) begin ob = mm[adrb]; kb = &mk[adrb]; end
        // B's lanes land first so that A's overwrite them: port A has per-lane priority.
        if (gb && web && ib)
            for (int i = 0; i < BYTES; i++)
                if (beb[i]) begin mm[adrb][8*i +: 8] = wdb[8*i +: 8]; mk[adrb][i] = 1'b1; end
        if (ga && wea && ia)
            for (int i = 0; i < BYTES; i++)
                if (bea[i]) begin mm[adra][8*i +: 8] = wda[8*i +: 8]; mk[adra][i] = 1'b1; end
        fa = '0; fb = '0; kfa = 1'b1; kfb = 1'b1;
        if (ia) begin fa = mm[adra]; kfa = &mk[adra]; end
        if (ib) begin fb = mm[adrb]; kfb = &mk[adrb]; end
        if (ga) begin push(0, 1, fa, kfa); push(2, 2, oa, ka); end
        if (gb) begin push(1, 1, fb, kfb); push(3, 2, ob, kb); end

        @(posedge clk);
        #1;
        cyc++;
        if (r && clr_left > 0) clr_left--;
        s = cyc % 4;
        for (int c = 0; c < 4; c++) begin
            if (pv[c][s]) begin
                check($sformatf("rvalid_ch%0d", c), W'(got_v(c)), W'(1'b1));
                if (pk[c][s]) check($sformatf("rd_ch%0d", c), got_d(c), pd[c][s]);
                last_d[c] = pd[c][s];
                last_k[c] = pk[c][s];
                pv[c][s]  = 1'b0;
            end else begin
                check($sformatf("rvalid_idle_ch%0d", c), W'(got_v(c)), W'(1'b0));
                if (last_k[c]) check($sformatf("rd_hold_ch%0d", c), got_d(c), last_d[c]);
            end
        end
        check("busy_wf1", W'(busy0), W'(CLEAR && clr_left > 0));
        check("busy_rf2", W'(busy1), W'(CLEAR && clr_left > 0));
    endtask

    task automatic set_a(input logic e, input logic w, input logic [BYTES-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        ena = e; wea = w; bea = be; adra = a; wda = d;
    endtask

    task automatic set_b(input logic e, input logic w, input logic [BYTES-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        enb = e; web = w; beb = be; adrb = a; wdb = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [ADDR_W-1:0] rnd_adr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return ADDR_W'($urandom_range(0, 7));
        if (r < 9) return ADDR_W'($urandom_range(0, DEPTH - 1));
        return ADDR_W'($urandom_range(DEPTH, 2**ADDR_W - 1));
    endfunction

    task automatic rnd_ports();
        set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, BYTES'($urandom), rnd_adr(), $urandom);
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, BYTES'($urandom), rnd_adr(), $urandom);
    endtask

    int nb;

    initial begin
        tests = 0; fails = 0; cyc = 0; nb = 0;
        for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = '0; end
        rstn = 1'b0;
        idle();
        model_reset();
        repeat (3) step();
        rstn = 1'b1;

        // Fill every word; with the clear engine built, the first DEPTH cycles are ignored.
        for (int i = 0; i < DEPTH + 4; i++) begin
            set_a(1'b1, 1'b1, '1, ADDR_W'(i % DEPTH), $urandom);
            set_b(1'b1, 1'b1, '1, ADDR_W'(DEPTH - 1 - (i % DEPTH)), $urandom);
            if (busy0) nb++;
            step();
        end
        check("busy_cycles", W'(nb), CLEAR ? W'(DEPTH) : W'(0));
        idle();

        // Byte-lane write then read of word 5.
        set_a(1'b1, 1'b1, 4'b1111, 6'd5, 32'h1122_3344); step();
        set_a(1'b1, 1'b1, 4'b0010, 6'd5, 32'hAABB_CCDD); step();
        set_a(1'b1, 1'b0, 4'b0000, 6'd5, 32'h0);         step();
        check("byte_rd", rda0, 32'h1122_CC44);
        check("byte_rvalid", W'(rvalida0), W'(1'b1));
        idle(); step();
        check("byte_pulse", W'(rvalida0), W'(1'b0));

        // Write-first vs read-first return data on a full write of word 9.
        set_a(1'b1, 1'b1, 4'b1111, 6'd9, 32'h0);         step();
        set_a(1'b1, 1'b1, 4'b1111, 6'd9, 32'hFFFF_FFFF); step();
        check("wmode_wf", rda0, 32'hFFFF_FFFF);
        idle(); step();
        check("wmode_rf", rda1, 32'h0000_0000);
        set_a(1'b1, 1'b0, 4'b0000, 6'd9, 32'h0); step();
        check("wmode_read_wf", rda0, 32'hFFFF_FFFF);
        idle(); step();
        check("wmode_read_rf", rda1, 32'hFFFF_FFFF);

        // Dual-write collision at word 3.
        set_a(1'b1, 1'b1, 4'b1111, 6'd3, 32'h1122_3344); step();
        set_a(1'b1, 1'b1, 4'b0001, 6'd3, 32'h0000_00AA);
        set_b(1'b1, 1'b1, 4'b0011, 6'd3, 32'hBBBB_BBBB); step();
        check("coll_a", rda0, 32'h1122_BBAA);
        check("coll_b", rdb0, 32'h1122_BBAA);
        idle();
        set_a(1'b1, 1'b0, 4'b0000, 6'd3, 32'h0); step();
        check("coll_read", rda0, 32'h1122_BBAA);

        // Cross-port: A writes word 7 while B reads it.
        idle();
        set_a(1'b1, 1'b1, 4'b1111, 6'd7, 32'h0);         step();
        set_a(1'b1, 1'b1, 4'b1111, 6'd7, 32'h1234_5678);
        set_b(1'b1, 1'b0, 4'b0000, 6'd7, 32'h0);         step();
        check("cross_wf", rdb0, 32'h1234_5678);
        idle(); step();
        check("cross_rf", rdb1, 32'h0000_0000);

        // Out-of-range read returns zero but still pulses rvalid.
        set_a(1'b1, 1'b0, 4'b0000, ADDR_W'(DEPTH), 32'h0); step();
        check("oor_rd", rda0, 32'h0);
        check("oor_rvalid", W'(rvalida0), W'(1'b1));

        // Back-to-back reads on both ports, then reset with reads in flight.
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b0, '0, ADDR_W'(i), '0);
            set_b(1'b1, 1'b0, '0, ADDR_W'(i + 4), '0);
            step();
        end
        #1 rstn = 1'b0;
        #1;
        idle();
        model_reset();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_rd_ch%0d", c), got_d(c), '0);
            check($sformatf("rst_rvalid_ch%0d", c), W'(got_v(c)), W'(1'b0));
        end
        check("rst_busy", W'(busy0), W'(CLEAR));
        repeat (2) step();
        rstn = 1'b1;
        repeat (3) step();

        // Random traffic; accesses during a post-reset clear must be ignored.
        for (int i = 0; i < DEPTH + 400; i++) begin
            rnd_ports();
            step();
        end

        // Read sweep of every word on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b1, 1'b0, '0, ADDR_W'(i), '0);
            set_b(1'b1, 1'b0, '0, ADDR_W'(DEPTH - 1 - i), '0);
            step();
        end
        idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bram_dp.md
Name: bram_dp

Overview:
- Parametrised true dual-port byte-enabled block RAM; successor to the single-port 4-byte BRAM.
- Two independent ports, A and B, on one clock; each has its own enable, byte-lane writes, and read-valid strobe.
- Configurable read latency, write mode and collision resolution between ports.
- Used as main-memory and video-buffer store in the RISC5 system, e.g. CPU on port A, display/DMA on port B.

Parameters:
BYTES, 4, number of 8-bit lanes; data width W = 8*BYTES
ADDR_W, 15, address width in words
DEPTH, 24576, number of implemented words; must be <= 2**ADDR_W
LATENCY, 1, read latency in cycles; legal values 1 or 2
WRITE_FIRST, 1, 1 = write-first read data on write/collision; 0 = read-first

Ports:
clka  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
ena  in  1  port A access request, one access per cycle
wea  in  1  port A write (qualified by ena)
bea  in  BYTES  port A byte-lane enables for writes
adra  in  ADDR_W  port A word address
wda  in  W  port A write data
rda  out  W  port A read data
rvalida  out  1  port A read data valid, one-cycle pulse
enb, web, beb, adrb, wdb, rdb, rvalidb  same as port A, for port B
busy  out  1  memory-clear engine active; constant 0 when the optional feature is compiled out

Behaviour:
- Reset (rstn=0, asynchronous):
  - rda, rdb = 0; rvalida, rvalidb = 0; busy as in Optional Feature; pipeline stages flushed.
  - Memory contents are not reset.
- Reset asserted mid-operation: in-flight reads are dropped and never produce an rvalid pulse.
- Access: a port accesses memory on a cycle with en=1 (and busy=0).
  - Read when we=0.
  - Write when we=1: for each lane i with be[i]=1, byte i of wd is written to mem[adr].
  - Write with be=0: no memory change; still counts as an access and still returns read data.
- Every access returns read data:
  - LATENCY=1: rd is updated at the edge ending the access cycle; rvalid=1 for the following cycle.
  - LATENCY=2: one extra register stage; rd and rvalid are delayed one more cycle.
- rd holds its last value when there is no access; rvalid=0 on non-access cycles.
- Read data on a write access:
  - WRITE_FIRST=1: merged word; new bytes on enabled lanes, old bytes elsewhere.
  - WRITE_FIRST=0: old contents.
- Out of range (adr >= DEPTH): writes are ignored; read data = 0; rvalid still pulses.
- Same address on both ports, same cycle:
  - Both write: per lane, if bea[i]=1 port A's byte is stored; else if beb[i]=1 port B's byte is stored.
  - One port reads while the other writes: the reader sees the post-write word if WRITE_FIRST=1, the pre-write word if WRITE_FIRST=0.
  - Both write with WRITE_FIRST=1: both ports return the final stored word.
  - Both read: both return the same word.
- Different addresses: ports are fully independent.
- Back-to-back accesses on either port are accepted every cycle; throughput is one access per port per cycle.

Optional Feature:
- Macro: BRAM_DP_CLEAR_EN.
- Defined:
  - busy=1 from reset assertion, and stays 1 while rstn=0.
  - After rstn releases, the clear counter writes 0 to addresses 0..DEPTH-1, one word per cycle.
  - busy falls after exactly DEPTH cycles.
  - While busy=1, ena/enb are ignored: no writes, rvalid stays 0.
  - Reset during clear restarts the counter at 0.
- Undefined: no clear engine; busy tied 0; power-up memory contents unspecified; ports are usable on the first cycle after reset release.

Test Plan:
- Byte write/read, LATENCY=1: write mem[5]=0x11223344 (bea=1111), then wea=1, bea=0010, wda=0xAABBCCDD → reads as 0x1122CC44; read of 5 gives rda=0x1122CC44 with rvalida high exactly one cycle after ena.
- Write mode (mem[9]=0x0, write 0xFFFFFFFF to 9 with bea=1111): WRITE_FIRST=1 → rda=0xFFFFFFFF on the write access; WRITE_FIRST=0 → rda=0x00000000; a later read of 9 returns 0xFFFFFFFF in both modes.
- Dual-write collision at address 3: A writes 0x000000AA with bea=0001; B writes 0xBBBBBBBB with beb=0011 → mem[3] low half = 0xBBAA, upper bytes unchanged.
- Cross-port read/write: A writes 0x12345678 to 7 while B reads 7 (old value 0) → rdb=0x12345678 if WRITE_FIRST=1, 0 if WRITE_FIRST=0.
- Latency and reset: LATENCY=2, issue reads on 4 consecutive cycles → rvalid pulses 2 cycles later, back to back; assert rstn=0 with reads in flight → rvalid=0, rd=0 immediately; no late pulses after release; read of adr=DEPTH → rd=0 with rvalid pulse.
- With BRAM_DP_CLEAR_EN: fill memory, reset with DEPTH=16 → busy high for 16 cycles after release with ena ignored; afterwards every word reads 0.
